riscv_div: RTL and testbench

RISCV_DIV -- requirements
Module: riscv_div

---
 rtl/riscv_div_pkg.sv | 24 ++
 rtl/riscv_div_step.sv | 22 ++
 rtl/riscv_div.sv | 137 +++++++++++++
 tb/tb_riscv_div.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/riscv_div_pkg.sv
// Shared constants, op encoding and FSM state type for the iterative RV32M divider.
package riscv_div_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 6;
    localparam int unsigned REM_W = XLEN + 1;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE = 2'd0;
    localparam state_t S_CALC = 2'd1;
    localparam state_t S_DONE = 2'd2;

    // Two's-complement negate when neg is set; also used for magnitude extraction.
    function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] x, input logic neg);
        return neg ? XLEN'(-x) : x;
    endfunction

endpackage

// File: rtl/riscv_div_step.sv
// One restoring shift-subtract iteration: shift in the next dividend bit, subtract if it fits.
module riscv_div_step
    import riscv_div_pkg::*;
(
    input  logic [REM_W-1:0] rem,
    input  logic             shift_in,
    input  logic [XLEN-1:0]  divisor,
    output logic [REM_W-1:0] next_rem,
    output logic             q_bit
);

    logic [REM_W:0]   shifted;
    logic [REM_W+1:0] diff;

    always_comb begin
        shifted  = {rem, shift_in};
        diff     = {1'b0, shifted} - (REM_W+2)'(divisor);
        q_bit    = ~diff[REM_W+1];
        next_rem = REM_W'(q_bit ? diff[REM_W:0] : shifted);
    end

endmodule

// File: rtl/riscv_div.sv
// Multi-cycle RV32M DIV/DIVU/REM/REMU unit: 32-step restoring divider with valid/ready handshakes.
module riscv_div
    import riscv_div_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [1:0]      op,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out,
    output logic            ZF,
    output logic            SF
);

    state_t            state;
    state_t            state_d;
    logic [CNT_W-1:0]  cnt;
    logic [REM_W-1:0]  rem;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   dvsr;
    logic              neg_q;
    logic              neg_r;
    logic              is_rem;

    logic              in_signed_c;
    logic              a_neg_c;
    logic              b_neg_c;
    logic              b_zero_c;
    logic              ovf_c;
    logic              special_c;
    logic [XLEN-1:0]   special_res_c;
    logic [REM_W-1:0]  next_rem_c;
    logic              q_bit_c;
    logic              last_c;
    logic [XLEN-1:0]   q_fin_c;
    logic [XLEN-1:0]   calc_res_c;
    logic              load_out_c;
    logic [XLEN-1:0]   res_c;

    riscv_div_step u_step (
        .rem      (rem),
        .shift_in (quo[XLEN-1]),
        .divisor  (dvsr),
        .next_rem (next_rem_c),
        .q_bit    (q_bit_c)
    );

    // Request decode and result selection.
    always_comb begin
        in_signed_c   = ~op[0];
        a_neg_c       = in_signed_c & a[XLEN-1];
        b_neg_c       = in_signed_c & b[XLEN-1];
        b_zero_c      = (b == '0);
        ovf_c         = in_signed_c & (a == XLEN'(32'h8000_0000)) & (b == '1);
        special_c     = b_zero_c | ovf_c;
        if (b_zero_c) begin
            special_res_c = op[1] ? a : '1;
        end else begin
            special_res_c = op[1] ? '0 : XLEN'(32'h8000_0000);
        end
        last_c     = (cnt == CNT_W'(XLEN - 1));
        q_fin_c    = {quo[XLEN-2:0], q_bit_c};
        calc_res_c = is_rem ? cond_neg(next_rem_c[XLEN-1:0], neg_r) : cond_neg(q_fin_c, neg_q);
        load_out_c = ((state == S_IDLE) & in_valid & special_c) | ((state == S_CALC) & last_c);
        res_c      = (state == S_IDLE) ? special_res_c : calc_res_c;
    end

    // Next-state logic.
    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:  if (in_valid) state_d = special_c ? S_DONE : S_CALC;
            S_CALC:  if (last_c) state_d = S_DONE;
            S_DONE:  if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State register with registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state     <= state_d;
            in_ready  <= (state_d == S_IDLE);
            out_valid <= (state_d == S_DONE);
        end
    end

    // Datapath: operand capture, iteration, result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            rem    <= '0;
            quo    <= '0;
            dvsr   <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            is_rem <= 1'b0;
            out    <= '0;
            ZF     <= 1'b0;
            SF     <= 1'b0;
        end else begin
            if (load_out_c) begin
                out <= res_c;
                ZF  <= (res_c == '0);
                SF  <= res_c[XLEN-1];
            end
            case (state)
                S_IDLE: begin
                    if (in_valid && !special_c) begin
                        cnt    <= '0;
                        rem    <= '0;
                        quo    <= cond_neg(a, a_neg_c);
                        dvsr   <= cond_neg(b, b_neg_c);
                        neg_q  <= a_neg_c ^ b_neg_c;
                        neg_r  <= a_neg_c;
                        is_rem <= op[1];
                    end
                end
                S_CALC: begin
                    cnt <= cnt + CNT_W'(1);
                    rem <= next_rem_c;
                    quo <= q_fin_c;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_div.sv
// Self-checking bench for riscv_div: directed corner cases plus random ops against a longint model.
module tb_riscv_div;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out;
    logic        ZF;
    logic        SF;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    riscv_div dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .ZF        (ZF),
        .SF        (SF)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference result from RISC-V division semantics using 64-bit arithmetic.
    function automatic logic [31:0] ref_res(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx;
        longint sy;
        longint r;
        if (y == 32'd0) return o[1] ? x : 32'hFFFF_FFFF;
        if (!o[0]) begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
        end else begin
            sx = longint'({32'd0, x});
            sy = longint'({32'd0, y});
        end
        r = o[1] ? (sx % sy) : (sx / sy);
        return r[31:0];
    endfunction

    function automatic int ref_lat(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        if (y == 32'd0) return 1;
        if (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Issue one request (called at posedge+1 with the unit idle) and check result and handshakes.
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input bit bp, input string tag);
        logic [31:0] exp;
        logic [31:0] held;
        int          lat;
        exp = ref_res(o, x, y);
        check({tag, ".in_ready_idle"}, 32'(in_ready), 32'd1);
        op        = o;
        a         = x;
        b         = y;
        in_valid  = 1'b1;
        out_ready = !bp;
        @(posedge clk); #1;
        check({tag, ".in_ready_busy"}, 32'(in_ready), 32'd0);
        // Garbage on the request port must be ignored while busy.
        a   = $urandom;
        b   = $urandom;
        op  = 2'($urandom);
        lat = 1;
        while (out_valid !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        in_valid = 1'b0;
        check({tag, ".latency"}, 32'(lat), 32'(ref_lat(o, x, y)));
        check({tag, ".out"}, out, exp);
        check({tag, ".ZF"}, 32'(ZF), 32'(exp == 32'd0));
        check({tag, ".SF"}, 32'(SF), 32'(exp[31]));
        if (bp) begin
            held = out;
            repeat (10) begin
                @(posedge clk); #1;
                check({tag, ".bp_out"}, out, held);
                check({tag, ".bp_valid"}, 32'(out_valid), 32'd1);
                check({tag, ".bp_in_ready"}, 32'(in_ready), 32'd0);
            end
            out_ready = 1'b1;
        end
        @(posedge clk); #1;
        check({tag, ".post_valid"}, 32'(out_valid), 32'd0);
        check({tag, ".post_in_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [1:0]  ro;
        logic [31:0] rx;
        logic [31:0] ry;
        bit          spurious;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = 32'd0;
        b         = 32'd0;
        op        = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        check("rst.in_ready", 32'(in_ready), 32'd1);
        check("rst.out_valid", 32'(out_valid), 32'd0);
        check("rst.out", out, 32'd0);
        check("rst.ZF", 32'(ZF), 32'd0);
        check("rst.SF", 32'(SF), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_op(2'b01, 32'd100, 32'd7, 1'b0, "divu_100_7");
        run_op(2'b11, 32'd100, 32'd7, 1'b0, "remu_100_7");
        run_op(2'b00, 32'hFFFF_FFF9, 32'd2, 1'b0, "div_m7_2");
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, "rem_m7_2");
        run_op(2'b01, 32'd5, 32'd0, 1'b0, "divu_by0");
        run_op(2'b11, 32'd5, 32'd0, 1'b0, "remu_by0");
        run_op(2'b10, 32'hFFFF_FFFB, 32'd0, 1'b0, "rem_neg_by0");
        run_op(2'b00, 32'd0, 32'd3, 1'b0, "div_0_3");
        run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_ovf");
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "rem_ovf");
        run_op(2'b00, 32'd100, 32'hFFFF_FFF9, 1'b0, "div_100_m7");
        run_op(2'b01, 32'hFFFF_FFFF, 32'd1, 1'b0, "divu_max_1");
        run_op(2'b01, 32'd1000, 32'd9, 1'b1, "divu_bp");
        run_op(2'b10, 32'h8000_0001, 32'd3, 1'b1, "rem_bp");

        // Reset during CALC must abort silently.
        op       = 2'b01;
        a        = 32'd1000;
        b        = 32'd3;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort.in_ready", 32'(in_ready), 32'd1);
        check("abort.out_valid", 32'(out_valid), 32'd0);
        spurious = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) spurious = 1'b1;
        end
        check("abort.no_pulse", 32'(spurious), 32'd0);
        run_op(2'b01, 32'd9, 32'd3, 1'b0, "divu_9_3");

        for (int i = 0; i < 24; i++) begin
            ro = 2'($urandom);
            rx = $urandom;
            case ($urandom_range(0, 6))
                0:       ry = 32'd0;
                1:       ry = 32'($urandom_range(1, 15));
                2:       ry = 32'hFFFF_FFFF;
                3:       ry = rx;
                default: ry = $urandom;
            endcase
            if (i % 5 == 0) rx = 32'h8000_0000;
            run_op(ro, rx, ry, (i % 6) == 0, $sformatf("rand%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
